// File: rtl/bcd_seq_display_pkg.sv
// Shared types and constants for the sequential binary-to-BCD display block.
package bcd_pkg;

  // Conversion controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Active-low segment pattern with every segment switched off.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Digit value shown in every position when the result saturates.
  localparam logic [3:0] BCD_NINE = 4'd9;

endpackage

// File: rtl/bcd_seq_display_if.sv
// Request/result bundle between a requester and the BCD display converter.
interface bcd_seq_display_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      b;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [4*DIGITS-1:0]   bcd;
  logic [7*DIGITS-1:0]   seg;

  // Requester side: issues start/b, observes status and result.
  modport master (
    output start, b,
    input  busy, done, overflow, bcd, seg
  );

  // Converter side.
  modport slave (
    input  start, b,
    output busy, done, overflow, bcd, seg
  );
endinterface

// File: rtl/bcd_seq_display_hexdisplay.sv
// Single-digit hex to active-low 7-segment decoder.
// seg bit 0 = segment a ... bit 6 = segment g.
module hexdisplay
  import bcd_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Pattern lookup for one nibble.
  always_comb begin
    case (hex)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      4'hF:    seg = 7'b0001110;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_seq_display.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock)
// with saturating overflow and leading-zero-blanked 7-segment outputs.
module bcd_seq_display
  import bcd_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  bcd_seq_display_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{BCD_NINE}};

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    sh_q, sh_d;
  logic [4*DIGITS-1:0] acc_q, acc_d;
  logic                ovf_trk_q, ovf_trk_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;

  logic [4*DIGITS-1:0] acc_fix_s;
  logic [4*DIGITS-1:0] acc_shift_s;
  logic [DIGITS-1:0]   blank_s;
  logic                lead_seen_s;
  logic [7*DIGITS-1:0] dec_s;
  logic [7*DIGITS-1:0] seg_s;

  // Add-3 correction on each accumulator digit before it is doubled.
  for (genvar g = 0; g < DIGITS; g++) begin : g_fix
    assign acc_fix_s[4*g +: 4] = (acc_q[4*g +: 4] >= 4'd5) ?
                                 (acc_q[4*g +: 4] + 4'd3) : acc_q[4*g +: 4];
  end

  // Next operand bit enters digit 0; the top digit's MSB falls off.
  assign acc_shift_s = {acc_fix_s[4*DIGITS-2:0], sh_q[WIDTH-1]};

  // Next-state and datapath control for the conversion sequence.
  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    acc_d     = acc_q;
    ovf_trk_d = ovf_trk_q;
    cnt_d     = cnt_q;
    ready_d   = 1'b1;
    done_d    = 1'b0;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    case (state_q)
      ST_IDLE: begin
        // ready_q keeps the first edge after reset release from accepting.
        if (bus.start && ready_q) begin
          sh_d      = bus.b;
          acc_d     = '0;
          ovf_trk_d = 1'b0;
          cnt_d     = CW'(WIDTH);
          state_d   = ST_SHIFT;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        acc_d     = acc_shift_s;
        sh_d      = {sh_q[WIDTH-2:0], 1'b0};
        ovf_trk_d = ovf_trk_q | acc_fix_s[4*DIGITS-1];
        cnt_d     = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        bcd_d   = ovf_trk_q ? ALL_NINES : acc_q;
        ovf_d   = ovf_trk_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_SHIFT) || (state_d == ST_DONE);
  end

  // State, datapath and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sh_q      <= '0;
      acc_q     <= '0;
      ovf_trk_q <= 1'b0;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      bcd_q     <= '0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      acc_q     <= acc_d;
      ovf_trk_q <= ovf_trk_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      bcd_q     <= bcd_d;
    end
  end

  // Blank zero digits above the most significant nonzero digit; digit 0 always shows.
  always_comb begin
    lead_seen_s = 1'b0;
    blank_s     = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lead_seen_s = lead_seen_s | (|bcd_q[4*i +: 4]);
      blank_s[i]  = BLANK_LZ && !lead_seen_s && (i != 0);
    end
  end

  // Per-digit decode of the registered result only.
  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    hexdisplay u_hex (
      .hex (bcd_q[4*g +: 4]),
      .seg (dec_s[7*g +: 7])
    );
    assign seg_s[7*g +: 7] = blank_s[g] ? SEG_BLANK : dec_s[7*g +: 7];
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;
  assign bus.bcd      = bcd_q;
  assign bus.seg      = seg_s;

endmodule
